// File: rtl/rtc_timekeeper.sv
// HH:MM:SS BCD real-time clock with 1 Hz prescaler, debounced time-set buttons
// and 12/24-hour seven-segment display output.
module rtc_timekeeper #(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int DEBOUNCE_SAMPLES = 8
) (
  input  logic            clock50MHz,
  input  logic            resetn,
  input  logic            man_switch,
  input  logic            mode_12h,
  input  logic [2:0]      push_button,
  output logic            tick_out,
  output logic [23:0]     bcd_time,
  output logic            pm,
  output logic [5:0][6:0] seven_seg
);
  localparam int PRESC_W = $clog2(CLK_FREQ_HZ);
  localparam int MS_DIV  = CLK_FREQ_HZ / 1000;
  localparam int MS_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int DB      = DEBOUNCE_SAMPLES;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);
  localparam logic [MS_W-1:0]    MS_MAX    = MS_W'(MS_DIV - 1);

  function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] top);
    if (v == top) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  logic [1:0]          man_sync_q, mode_sync_q;
  logic [1:0][2:0]     btn_sync_q;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [MS_W-1:0]     ms_cnt_q, ms_cnt_d;
  logic [2:0][DB-1:0]  sh_q, sh_d;
  logic [2:0]          pressed_q, pressed_d, ev;
  logic [7:0]          sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic                tick, tick_q, tick_out_q, pm_q, pm_d, ms_stb;
  logic [23:0]         bcd_q;
  logic [5:0][6:0]     seg_q, seg_d;
  logic [4:0]          hr_bin, hr12, hr12_lo;
  logic [7:0]          disp_hr;
  logic                man_s, mode_s;
  logic [2:0]          btn_s;

  assign man_s  = man_sync_q[1];
  assign mode_s = mode_sync_q[1];
  assign btn_s  = btn_sync_q[1];

  always_comb begin
    tick     = !man_s && (presc_q == PRESC_MAX);
    presc_d  = (man_s || tick) ? '0 : presc_q + 1'b1;
    ms_stb   = (ms_cnt_q == MS_MAX);
    ms_cnt_d = ms_stb ? '0 : ms_cnt_q + 1'b1;
  end

  // Debounce: state flips only when every sample in the window agrees
  always_comb begin
    sh_d      = sh_q;
    pressed_d = pressed_q;
    ev        = '0;
    for (int i = 0; i < 3; i++) begin
      if (ms_stb) begin
        sh_d[i] = {sh_q[i][DB-2:0], btn_s[i]};
        if (sh_d[i] == '0)     pressed_d[i] = 1'b1;
        else if (&sh_d[i])     pressed_d[i] = 1'b0;
      end
      ev[i] = pressed_d[i] & ~pressed_q[i];
    end
  end

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (man_s) begin
      if (ev[0]) sec_d = inc_wrap(sec_q, 8'h59);
      if (ev[1]) min_d = inc_wrap(min_q, 8'h59);
      if (ev[2]) hr_d  = inc_wrap(hr_q, 8'h23);
    end else if (tick) begin
      sec_d = inc_wrap(sec_q, 8'h59);
      if (sec_q == 8'h59) begin
        min_d = inc_wrap(min_q, 8'h59);
        if (min_q == 8'h59) hr_d = inc_wrap(hr_q, 8'h23);
      end
    end
  end

  // 12-hour view maps 0 -> 12 and 13..23 -> 1..11; H1 blanks when zero
  always_comb begin
    hr_bin  = 5'(hr_q[7:4]) * 5'd10 + 5'(hr_q[3:0]);
    pm_d    = (hr_bin >= 5'd12);
    hr12    = (hr_bin == 5'd0) ? 5'd12 : ((hr_bin > 5'd12) ? hr_bin - 5'd12 : hr_bin);
    hr12_lo = hr12 - 5'd10;
    if (!mode_s)            disp_hr = hr_q;
    else if (hr12 >= 5'd10) disp_hr = {4'd1, hr12_lo[3:0]};
    else                    disp_hr = {4'd0, hr12[3:0]};
    seg_d[0] = seg7(sec_q[3:0]);
    seg_d[1] = seg7(sec_q[7:4]);
    seg_d[2] = seg7(min_q[3:0]);
    seg_d[3] = seg7(min_q[7:4]);
    seg_d[4] = seg7(disp_hr[3:0]);
    seg_d[5] = (mode_s && disp_hr[7:4] == 4'd0) ? 7'h7F : seg7(disp_hr[7:4]);
  end

  always_ff @(posedge clock50MHz) begin
    if (!resetn) begin
      man_sync_q  <= '0;
      mode_sync_q <= '0;
      btn_sync_q  <= '1;
      presc_q     <= '0;
      ms_cnt_q    <= '0;
      sh_q        <= '1;
      pressed_q   <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      tick_q      <= 1'b0;
      tick_out_q  <= 1'b0;
      bcd_q       <= '0;
      pm_q        <= 1'b0;
      seg_q       <= {6{7'h7F}};
    end else begin
      man_sync_q  <= {man_sync_q[0], man_switch};
      mode_sync_q <= {mode_sync_q[0], mode_12h};
      btn_sync_q  <= {btn_sync_q[0], push_button};
      presc_q     <= presc_d;
      ms_cnt_q    <= ms_cnt_d;
      sh_q        <= sh_d;
      pressed_q   <= pressed_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      tick_q      <= tick;
      tick_out_q  <= tick_q;
      bcd_q       <= {hr_q, min_q, sec_q};
      pm_q        <= pm_d;
      seg_q       <= seg_d;
    end
  end

  assign tick_out  = tick_out_q;
  assign bcd_time  = bcd_q;
  assign pm        = pm_q;
  assign seven_seg = seg_q;

endmodule
